// File: rtl/icache_fill_responder.sv
// icache_fill_responder
//   Memory-side responder for the L1 instruction-cache line-fill interface.
//   A line request (pmem_read/pmem_address) is answered with a full 128-bit
//   line built from eight in-order 16-bit reads on the backing-memory port.
//   A single-line buffer answers a repeated request to the same line without
//   touching backing memory (when HIT_BUFFER_EN is set).
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   pmem_read     : L1 line read request, held until pmem_resp
//   pmem_address  : L1 byte address, bits [3:0] ignored
//   pmem_rdata    : line data, word i at [16i+15:16i]
//   pmem_resp     : one-cycle response pulse
//   flush         : invalidate the line buffer
//   mem_read      : backing-memory word read request
//   mem_address   : backing-memory word byte address
//   mem_rdata     : backing-memory word data
//   mem_resp      : backing-memory word response (one cycle)
`timescale 1ns/1ps
module icache_fill_responder #(
  parameter bit HIT_BUFFER_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic [15:0]  pmem_address,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  input  logic         flush,
  output logic         mem_read,
  output logic [15:0]  mem_address,
  input  logic [15:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [11:0]  req_tag;
  logic [11:0]  tag;
  logic         valid;
  logic         flush_seen;
  logic [2:0]   k;
  logic [127:0] line;

  logic hit;
  logic accept_miss;
  logic word_done;
  logic last_word;
  logic unused_addr_bits;

  // Low address bits select a byte within the line and play no role here.
  assign unused_addr_bits = ^pmem_address[3:0];

  // A coincident flush must force the miss path even if the buffer matches.
  assign hit         = HIT_BUFFER_EN && valid && (tag == pmem_address[15:4]) && !flush;
  assign accept_miss = (state == IDLE) && pmem_read && !hit;
  assign word_done   = (state == FETCH) && mem_resp;
  assign last_word   = word_done && (k == 3'd7);

  // Outputs come straight from registered state so they are glitch-free and
  // fall immediately when the asynchronous reset lands.
  assign pmem_resp   = (state == RESP);
  assign pmem_rdata  = line;
  assign mem_read    = (state == FETCH);
  assign mem_address = mem_read ? {req_tag, k, 1'b0} : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pmem_read) begin
          state_nxt = hit ? RESP : FETCH;
        end
      end
      FETCH: begin
        if (last_word) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tag    <= 12'h000;
      tag        <= 12'h000;
      valid      <= 1'b0;
      flush_seen <= 1'b0;
      k          <= 3'd0;
      line       <= 128'h0;
    end else begin
      if (accept_miss) begin
        req_tag    <= pmem_address[15:4];
        k          <= 3'd0;
        flush_seen <= 1'b0;
      end

      // Flush outside a fill kills the buffer at once; inside a fill it is
      // remembered so the completing line is returned but not retained.
      if (flush && (state != FETCH)) begin
        valid <= 1'b0;
      end
      if (flush && (state == FETCH)) begin
        flush_seen <= 1'b1;
      end

      if (word_done) begin
        line[{k, 4'h0} +: 16] <= mem_rdata;
        k                     <= k + 3'd1;
      end

      // Invalidate for the duration of a fill so a partial line never hits.
      if (accept_miss) begin
        valid <= 1'b0;
      end

      if (last_word) begin
        tag   <= req_tag;
        valid <= HIT_BUFFER_EN && !(flush_seen || flush);
      end
    end
  end

endmodule

// File: tb/tb_icache_fill_responder.sv
`timescale 1ns/1ps
module tb_icache_fill_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         preq;
  logic         sel;
  logic [15:0]  pmem_address;
  logic         flush;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  mem_base;

  logic         pmem_read0, pmem_read1;
  logic [127:0] pmem_rdata0, pmem_rdata1;
  logic         pmem_resp0, pmem_resp1;
  logic         mem_read0, mem_read1;
  logic [15:0]  mem_address0, mem_address1;

  logic [127:0] p_rdata;
  logic         p_resp;
  logic         m_read;
  logic [15:0]  m_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign pmem_read0 = preq & ~sel;
  assign pmem_read1 = preq & sel;
  assign p_rdata    = sel ? pmem_rdata1  : pmem_rdata0;
  assign p_resp     = sel ? pmem_resp1   : pmem_resp0;
  assign m_read     = sel ? mem_read1    : mem_read0;
  assign m_addr     = sel ? mem_address1 : mem_address0;

  icache_fill_responder #(.HIT_BUFFER_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read0),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata0),
    .pmem_resp    (pmem_resp0),
    .flush        (flush),
    .mem_read     (mem_read0),
    .mem_address  (mem_address0),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  icache_fill_responder #(.HIT_BUFFER_EN(1'b0)) dut_nobuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read1),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata1),
    .pmem_resp    (pmem_resp1),
    .flush        (flush),
    .mem_read     (mem_read1),
    .mem_address  (mem_address1),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One L1 request with a backing memory answering each word two cycles
  // after it is requested; word data = dbase + word index.
  // exp_lat > 0 : response must arrive that many cycles after the request.
  // exp_lat <= 0: response must arrive the cycle after the last word.
  task automatic run_req(input string name, input logic sel_i, input logic [15:0] addr,
                         input logic [15:0] dbase, input logic [15:0] exp_base,
                         input int exp_reads, input int exp_lat,
                         input int flush_at, input int abort_after);
    int           it       = 0;
    int           reads    = 0;
    int           words    = 0;
    int           resps    = 0;
    int           resp_it  = -1;
    int           it8      = -1;
    int           wait_cnt = 0;
    int           post     = 0;
    logic [15:0]  cur      = 16'h0000;
    logic [127:0] got      = '0;
    logic [127:0] exp_line = '0;
    logic [15:0]  exp_addr;

    sel          = sel_i;
    mem_base     = dbase;
    pmem_address = addr;
    preq         = 1'b1;
    flush        = (flush_at == 0);
    while (it < 400 && post < 4) begin
      @(negedge clk);
      it++;
      if (p_resp) begin
        resps++;
        got = p_rdata;
        if (resp_it < 0) resp_it = it;
        preq = 1'b0;
      end
      if (resp_it >= 0) post++;
      if (mem_resp) begin
        words++;
        if (words == 8) it8 = it;
        mem_resp = 1'b0;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_base + {13'd0, cur[3:1]};
        end
      end else if (m_read) begin
        exp_addr = {addr[15:4], reads[2:0], 1'b0};
        check({name, " mem_address"}, m_addr, exp_addr);
        reads++;
        cur      = m_addr;
        wait_cnt = 2;
      end
      flush = (it == flush_at);
      if (abort_after > 0 && words == abort_after) begin
        rst_n = 1'b0;
        #1;
        check({name, " mem_read in reset"}, m_read, 1'b0);
        check({name, " pmem_resp in reset"}, p_resp, 1'b0);
        check({name, " mem_address in reset"}, m_addr, 16'h0000);
        preq  = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    flush = 1'b0;
    preq  = 1'b0;
    for (int i = 0; i < 8; i++) exp_line[16*i +: 16] = exp_base + 16'(i);
    check({name, " resp_count"}, resps, 1);
    check({name, " read_count"}, reads, exp_reads);
    check({name, " rdata"}, got, exp_line);
    if (exp_lat > 0) check({name, " latency"}, resp_it, exp_lat);
    else             check({name, " latency"}, resp_it, it8);
  endtask

  initial begin
    rst_n        = 1'b0;
    preq         = 1'b0;
    sel          = 1'b0;
    pmem_address = 16'h0000;
    flush        = 1'b0;
    mem_rdata    = 16'h0000;
    mem_resp     = 1'b0;
    mem_base     = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset pmem_resp", pmem_resp0, 1'b0);
    check("reset mem_read", mem_read0, 1'b0);
    check("reset mem_address", mem_address0, 16'h0000);
    check("reset pmem_rdata", pmem_rdata0, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //      name          sel  addr      dbase     exp_base  reads lat flush abort
    run_req("cold_miss",  0, 16'h1236, 16'hA000, 16'hA000, 8,   0,  -1,   0);
    run_req("hit",        0, 16'h123A, 16'hB000, 16'hA000, 0,   1,  -1,   0);
    run_req("tag_change", 0, 16'h4450, 16'hC000, 16'hC000, 8,   0,  -1,   0);
    run_req("old_tag",    0, 16'h1230, 16'hD000, 16'hD000, 8,   0,  -1,   0);
    run_req("idle_flush", 0, 16'h1230, 16'hE000, 16'hE000, 8,   0,   0,   0);
    run_req("fetch_flush",0, 16'h2000, 16'h1000, 16'h1000, 8,   0,  20,   0);
    run_req("refetch",    0, 16'h2000, 16'h2000, 16'h2000, 8,   0,  -1,   0);
    run_req("hit2",       0, 16'h2000, 16'h3000, 16'h2000, 0,   1,  -1,   0);
    run_req("abort",      0, 16'h3000, 16'h4000, 16'h4000, 8,   0,  -1,   4);
    run_req("post_reset", 0, 16'h2000, 16'h5000, 16'h5000, 8,   0,  -1,   0);
    run_req("retry",      0, 16'h3000, 16'h6000, 16'h6000, 8,   0,  -1,   0);
    run_req("nobuf_1",    1, 16'h1230, 16'h7000, 16'h7000, 8,   0,  -1,   0);
    run_req("nobuf_2",    1, 16'h1230, 16'h8000, 16'h8000, 8,   0,  -1,   0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
